// File: rtl/key_cmd_pkg.sv
// Shared definitions for the keyboard command decoder: FSM encodings, PS/2 prefix
// codes and the default scan-code tables.
package key_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01
    } kc_state_e;

    localparam logic [7:0] KC_BREAK = 8'hF0;
    localparam logic [7:0] KC_EXT   = 8'hE0;

    localparam logic [7:0] KC_F1    = 8'h05;
    localparam logic [7:0] KC_F2    = 8'h06;
    localparam logic [7:0] KC_F3    = 8'h04;
    localparam logic [7:0] KC_F4    = 8'h0C;
    localparam logic [7:0] KC_F5    = 8'h03;
    localparam logic [7:0] KC_F12   = 8'h07;
    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_LEFT  = 8'h6B;
    localparam logic [7:0] KC_RIGHT = 8'h74;

    // Byte i of each table is the code for flag/strobe i.
    localparam logic [39:0] DEF_TOGGLE_CODES = {KC_F12, KC_F4, KC_F3, KC_F2, KC_F1};
    localparam logic [39:0] DEF_PULSE_CODES  = {KC_RIGHT, KC_LEFT, KC_DOWN, KC_UP, KC_F5};

endpackage

// File: rtl/key_code_match.sv
// Combinational scan-code comparator array: one match bit per table entry plus an
// any-match summary.
module key_code_match #(
    parameter int               N     = 5,
    parameter logic [8*N-1:0]   CODES = '0
) (
    input  logic [7:0]   code,
    output logic [N-1:0] match,
    output logic         any_match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < N; i++) begin
            match[i] = (CODES[8*i +: 8] == code);
        end
    end

    assign any_match = |match;

endmodule

// File: rtl/key_cmd_decoder.sv
// Decodes PicoBlaze scan-code writes into latched mode flags and one-cycle command
// strobes, with break-code suppression, E0 transparency and a post-write holdoff.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | waiting for a write to PORT_ADDR
//  ST_HOLD | holdoff after an accepted write; all writes ignored until the
//          | counter reads zero
module key_cmd_decoder
    import key_cmd_pkg::*;
#(
    parameter logic [7:0]            PORT_ADDR    = 8'h0A,
    parameter int                    N_TOGGLE     = 5,
    parameter int                    N_PULSE      = 5,
    parameter logic [8*N_TOGGLE-1:0] TOGGLE_CODES = DEF_TOGGLE_CODES,
    parameter logic [8*N_PULSE-1:0]  PULSE_CODES  = DEF_PULSE_CODES,
    parameter int                    HOLDOFF      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wrt_strobe,
    input  logic [7:0]          port_ID,
    input  logic [7:0]          tecla,
    output logic [N_TOGGLE-1:0] toggle_q,
    output logic [N_PULSE-1:0]  pulse_q,
    output logic [7:0]          code_q,
    output logic                code_stb,
    output logic                unknown_stb
);

    localparam bit         HAS_HOLD  = (HOLDOFF != 0);
    localparam logic [7:0] HOLD_LOAD = HAS_HOLD ? 8'(HOLDOFF - 1) : 8'd0;

    kc_state_e state, state_nxt;
    logic [7:0] hold_cnt, hold_cnt_d;
    logic       brk_pend, brk_pend_d;

    logic [N_TOGGLE-1:0] tog_match, toggle_d;
    logic [N_PULSE-1:0]  pul_match, pulse_d;
    logic                tog_any, pul_any;
    logic [7:0]          code_d;
    logic                code_stb_d, unknown_stb_d;
    logic                accept;

    key_code_match #(.N(N_TOGGLE), .CODES(TOGGLE_CODES)) u_toggle_match (
        .code      (tecla),
        .match     (tog_match),
        .any_match (tog_any)
    );

    key_code_match #(.N(N_PULSE), .CODES(PULSE_CODES)) u_pulse_match (
        .code      (tecla),
        .match     (pul_match),
        .any_match (pul_any)
    );

    assign accept = wrt_strobe && (port_ID == PORT_ADDR) && (state == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && HAS_HOLD) state_nxt = ST_HOLD;
            ST_HOLD: if (hold_cnt == 8'd0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        toggle_d      = toggle_q;
        pulse_d       = '0;
        code_d        = code_q;
        code_stb_d    = 1'b0;
        unknown_stb_d = 1'b0;
        brk_pend_d    = brk_pend;
        hold_cnt_d    = hold_cnt;

        if (state == ST_HOLD && hold_cnt != 8'd0) begin
            hold_cnt_d = hold_cnt - 8'd1;
        end

        if (accept) begin
            hold_cnt_d = HOLD_LOAD;
            if (tecla == KC_EXT) begin
                // extended prefix is transparent: the following byte decodes normally
            end else if (tecla == KC_BREAK) begin
                brk_pend_d = 1'b1;
            end else if (brk_pend) begin
                brk_pend_d = 1'b0;
            end else begin
                toggle_d      = toggle_q ^ tog_match;
                pulse_d       = tog_any ? '0 : pul_match;
                code_d        = tecla;
                code_stb_d    = 1'b1;
                unknown_stb_d = !tog_any && !pul_any;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt    <= 8'd0;
            brk_pend    <= 1'b0;
            toggle_q    <= '0;
            pulse_q     <= '0;
            code_q      <= 8'd0;
            code_stb    <= 1'b0;
            unknown_stb <= 1'b0;
        end else begin
            hold_cnt    <= hold_cnt_d;
            brk_pend    <= brk_pend_d;
            toggle_q    <= toggle_d;
            pulse_q     <= pulse_d;
            code_q      <= code_d;
            code_stb    <= code_stb_d;
            unknown_stb <= unknown_stb_d;
        end
    end

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Bench for key_cmd_decoder: a HOLDOFF=2 and a HOLDOFF=0 instance share stimulus and
// are compared against a write-level reference model.
module tb_key_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wrt_strobe = 1'b0;
    logic [7:0] port_ID = 8'd0;
    logic [7:0] tecla = 8'd0;

    logic [4:0] tq_a, pq_a, tq_b, pq_b;
    logic [7:0] cq_a, cq_b;
    logic       cs_a, us_a, cs_b, us_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_cmd_decoder #(.HOLDOFF(2)) dut_a (
        .clk(clk), .reset(reset), .wrt_strobe(wrt_strobe), .port_ID(port_ID), .tecla(tecla),
        .toggle_q(tq_a), .pulse_q(pq_a), .code_q(cq_a), .code_stb(cs_a), .unknown_stb(us_a)
    );

    key_cmd_decoder #(.HOLDOFF(0)) dut_b (
        .clk(clk), .reset(reset), .wrt_strobe(wrt_strobe), .port_ID(port_ID), .tecla(tecla),
        .toggle_q(tq_b), .pulse_q(pq_b), .code_q(cq_b), .code_stb(cs_b), .unknown_stb(us_b)
    );

    // Reference model: index 0 = HOLDOFF 2 instance, index 1 = HOLDOFF 0 instance.
    int         hv[2]        = '{2, 0};
    logic [7:0] tog_tab[5]   = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h07};
    logic [7:0] pul_tab[5]   = '{8'h03, 8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] code_pool[14] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h07, 8'h03, 8'h75,
                                  8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h55, 8'h00};
    logic [4:0] m_tog[2], m_pul[2];
    logic [7:0] m_code[2];
    logic       m_cs[2], m_us[2], m_brk[2];
    int         m_busy[2];

    function automatic logic [19:0] obs(input int k);
        return (k == 0) ? {tq_a, pq_a, cq_a, cs_a, us_a} : {tq_b, pq_b, cq_b, cs_b, us_b};
    endfunction

    function automatic logic [19:0] expv(input int k);
        return {m_tog[k], m_pul[k], m_code[k], m_cs[k], m_us[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_tog[k] = '0; m_pul[k] = '0; m_code[k] = '0;
            m_cs[k] = 0; m_us[k] = 0; m_brk[k] = 0; m_busy[k] = 0;
        end
    endtask

    task automatic model_edge(input logic w, input logic [7:0] p, input logic [7:0] d);
        bit hit_t, hit_p;
        for (int k = 0; k < 2; k++) begin
            m_pul[k] = '0; m_cs[k] = 0; m_us[k] = 0;
            if (m_busy[k] > 0) begin
                m_busy[k]--;
            end else if (w && p == 8'h0A) begin
                m_busy[k] = hv[k];
                if (d == 8'hE0) begin
                end else if (d == 8'hF0) begin
                    m_brk[k] = 1;
                end else if (m_brk[k]) begin
                    m_brk[k] = 0;
                end else begin
                    hit_t = 0; hit_p = 0;
                    for (int i = 0; i < 5; i++)
                        if (tog_tab[i] == d) begin m_tog[k][i] = ~m_tog[k][i]; hit_t = 1; end
                    for (int j = 0; j < 5; j++)
                        if (pul_tab[j] == d) begin
                            hit_p = 1;
                            if (!hit_t) m_pul[k][j] = 1'b1;
                        end
                    m_code[k] = d;
                    m_cs[k]   = 1;
                    m_us[k]   = !hit_t && !hit_p;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, leave the bus idle after.
    task automatic step(input logic w, input logic [7:0] p, input logic [7:0] d);
        wrt_strobe = w; port_ID = p; tecla = d;
        @(posedge clk);
        model_edge(w, p, d);
        #1;
        wrt_strobe = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 20'h0) begin
                errors++; $display("FAIL reset_outputs dut%0d got %h want 00000", k, obs(k));
            end
        end
    endtask

    task automatic test_toggle();
        apply_reset();
        step(1, 8'h0A, 8'h05);
        checks++;
        if ({tq_a[0], cq_a, cs_a} !== {1'b1, 8'h05, 1'b1}) begin
            errors++; $display("FAIL toggle_set got t0=%b code=%h stb=%b want 1 05 1", tq_a[0], cq_a, cs_a);
        end
        step(0, 8'h00, 8'h00);
        checks++;
        if (cs_a !== 1'b0) begin errors++; $display("FAIL code_stb_clear got %b want 0", cs_a); end
        step(0, 8'h00, 8'h00);
        step(1, 8'h0A, 8'h05);
        checks++;
        if (tq_a[0] !== 1'b0) begin errors++; $display("FAIL toggle_clear got %b want 0", tq_a[0]); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL toggle_model dut%0d got %h want %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_pulse();
        apply_reset();
        step(1, 8'h0A, 8'h75);
        checks++;
        if (pq_a !== 5'b00010) begin errors++; $display("FAIL pulse_up got %b want 00010", pq_a); end
        step(0, 8'h00, 8'h00);
        checks++;
        if (pq_a !== 5'b00000) begin errors++; $display("FAIL pulse_up_clear got %b want 00000", pq_a); end
        step(0, 8'h00, 8'h00);
        step(1, 8'h0A, 8'h03);
        checks++;
        if ({pq_a, tq_a} !== {5'b00001, 5'b00000}) begin
            errors++; $display("FAIL pulse_f5 got p=%b t=%b want 00001 00000", pq_a, tq_a);
        end
    endtask

    task automatic test_break();
        apply_reset();
        step(1, 8'h0A, 8'hF0);
        step(0, 8'h00, 8'h00);
        step(0, 8'h00, 8'h00);
        step(1, 8'h0A, 8'h06);
        checks++;
        if ({tq_a, pq_a, cs_a, us_a} !== 12'h0) begin
            errors++; $display("FAIL break_suppress got t=%b p=%b cs=%b us=%b want all 0", tq_a, pq_a, cs_a, us_a);
        end
        step(0, 8'h00, 8'h00);
        step(0, 8'h00, 8'h00);
        step(1, 8'h0A, 8'h06);
        checks++;
        if (tq_a !== 5'b00010) begin errors++; $display("FAIL break_then_make got %b want 00010", tq_a); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step(1, 8'h0A, 8'h04);
        step(1, 8'h0A, 8'h04);
        checks++;
        if (tq_a[2] !== 1'b1) begin errors++; $display("FAIL holdoff_ignore got %b want 1", tq_a[2]); end
        checks++;
        if (tq_b[2] !== 1'b0) begin errors++; $display("FAIL no_holdoff_both got %b want 0", tq_b[2]); end
    endtask

    task automatic test_port_unknown();
        apply_reset();
        step(1, 8'h0B, 8'h04);
        checks++;
        if ({tq_a, cs_a} !== 6'h0) begin errors++; $display("FAIL wrong_port got t=%b cs=%b want 0 0", tq_a, cs_a); end
        step(1, 8'h0A, 8'h55);
        checks++;
        if ({us_a, cq_a} !== {1'b1, 8'h55}) begin
            errors++; $display("FAIL unknown_set got us=%b code=%h want 1 55", us_a, cq_a);
        end
        step(0, 8'h00, 8'h00);
        checks++;
        if (us_a !== 1'b0) begin errors++; $display("FAIL unknown_clear got %b want 0", us_a); end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        step(1, 8'h0A, 8'h07);
        checks++;
        if (tq_a[4] !== 1'b1) begin errors++; $display("FAIL f12_set got %b want 1", tq_a[4]); end
        step(0, 8'h00, 8'h00);
        step(0, 8'h00, 8'h00);
        step(1, 8'h0A, 8'hF0);
        reset = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 20'h0) begin
                errors++; $display("FAIL async_reset dut%0d got %h want 00000", k, obs(k));
            end
        end
        @(negedge clk);
        reset = 1'b1;
        step(1, 8'h0A, 8'h07);
        checks++;
        if (tq_a !== 5'b10000) begin errors++; $display("FAIL after_reset_f12 got %b want 10000", tq_a); end
    endtask

    task automatic test_random();
        logic       w;
        logic [7:0] p, d;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            w = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 5) == 0) ? 8'h0B : 8'h0A;
            d = code_pool[$urandom_range(0, 13)];
            if (d == 8'h00) d = 8'($urandom);
            step(w, p, d);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++; $display("FAIL random_model n=%0d dut%0d got %h want %h", n, k, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_toggle();
        test_pulse();
        test_break();
        test_back_to_back();
        test_port_unknown();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
